// File: rtl/match_pkg.sv
// Shared types and constants for the match controller: the FSM state
// encoding (also exported on state_o for display logic) and side encodings.
package match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_WIN   = 3'd5
    } state_e;

    // A "side" names a player: used for serve_side, winner and the
    // conceding player of a goal.
    localparam logic SIDE_ONE = 1'b0;
    localparam logic SIDE_TWO = 1'b1;

endpackage

// File: rtl/serve_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that free-runs every cycle and
// provides the random serve side. Reset loads the seed.
module serve_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next value: shift left, feedback from stages 8,6,5,4; an all-zero
    // register (only reachable through a zero seed) is forced out of lockup.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (lfsr_q == 8'h00) begin
            lfsr_d = 8'h01;
        end
    end

    // State register with synchronous reset to the seed.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // pre-edge values regardless of block evaluation order.
        if (rst) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/match_controller.sv
// Match controller for a two-player ball game: serve hold, play, pause,
// point scoring and win detection with a random first serve.
// Optional build macro MATCH_CTRL_DEUCE_EN: a match is won only with a
// score of at least WIN_SCORE and a lead of two or more points; without it
// the first player to reach exactly WIN_SCORE wins.
module match_controller
    import match_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned SERVE_CYCLES = 150000000,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               goal_valid,
    input  logic               goal_side,
    input  logic               pause_req,
    output logic               game_active,
    output logic               serve_side,
    output logic               serve_go,
    output logic [SCORE_W-1:0] score_one,
    output logic [SCORE_W-1:0] score_two,
    output logic               match_over,
    output logic               winner,
    output logic [2:0]         state_o
);

    localparam int unsigned        CNT_W     = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    // Parameter sanity checks, reported at elaboration.
    if (WIN_SCORE + 1 > (2 ** SCORE_W) - 1) begin : g_chk_score_w
        $error("match_controller: WIN_SCORE+1 does not fit in SCORE_W bits");
    end
    if (SERVE_CYCLES < 1) begin : g_chk_serve
        $error("match_controller: SERVE_CYCLES must be at least 1");
    end
    if (LFSR_SEED == 8'h00) begin : g_chk_seed
        $error("match_controller: LFSR_SEED must be non-zero");
    end

    state_e             state_q,      state_d;
    logic [SCORE_W-1:0] score_one_q,  score_one_d;
    logic [SCORE_W-1:0] score_two_q,  score_two_d;
    logic [CNT_W-1:0]   serve_cnt_q,  serve_cnt_d;
    logic               serve_side_q, serve_side_d;
    logic               winner_q,     winner_d;
    logic               serve_go_q,   serve_go_d;
    logic               conceder_q,   conceder_d;

    logic [7:0]         lfsr_q;
    logic               lfsr_unused;
    logic [SCORE_W-1:0] new_score;
    logic               win_hit;

    serve_lfsr u_serve_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    // Only bit 0 chooses the serve; the remaining stages just keep the sequence long.
    assign lfsr_unused = ^lfsr_q[7:1];

    // The scorer is the player opposite the conceder; its score saturates.
    assign new_score = (conceder_q == SIDE_TWO)
                     ? ((score_one_q == SCORE_MAX) ? score_one_q : score_one_q + SCORE_W'(1))
                     : ((score_two_q == SCORE_MAX) ? score_two_q : score_two_q + SCORE_W'(1));

`ifdef MATCH_CTRL_DEUCE_EN
    logic [SCORE_W-1:0] other_score;

    assign other_score = (conceder_q == SIDE_TWO) ? score_two_q : score_one_q;
    // Win by two: widen by one bit so other_score+2 cannot overflow.
    assign win_hit = (new_score >= WIN_VAL) &&
                     ({1'b0, new_score} >= ({1'b0, other_score} + (SCORE_W+1)'(2)));
`else
    assign win_hit = (new_score == WIN_VAL);
`endif

    // Next-state and register-update logic for the match FSM.
    always_comb begin
        state_d      = state_q;
        score_one_d  = score_one_q;
        score_two_d  = score_two_q;
        serve_cnt_d  = '0;
        serve_side_d = serve_side_q;
        winner_d     = winner_q;
        serve_go_d   = 1'b0;
        conceder_d   = conceder_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SERVE;
                    serve_side_d = lfsr_q[0];
                end
            end
            ST_SERVE: begin
                if (serve_cnt_q == CNT_LAST) begin
                    state_d    = ST_PLAY;
                    serve_go_d = 1'b1;
                end else begin
                    serve_cnt_d = serve_cnt_q + CNT_W'(1);
                end
            end
            ST_PLAY: begin
                // A goal outranks a pause request arriving in the same cycle.
                if (goal_valid) begin
                    state_d    = ST_POINT;
                    conceder_d = goal_side;
                end else if (pause_req) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_req) begin
                    state_d = ST_PLAY;
                end
            end
            ST_POINT: begin
                if (conceder_q == SIDE_TWO) begin
                    score_one_d = new_score;
                end else begin
                    score_two_d = new_score;
                end
                serve_side_d = conceder_q;
                if (win_hit) begin
                    state_d  = ST_WIN;
                    winner_d = ~conceder_q;
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_WIN: begin
                if (start) begin
                    state_d      = ST_SERVE;
                    score_one_d  = '0;
                    score_two_d  = '0;
                    serve_side_d = lfsr_q[0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            score_one_q  <= '0;
            score_two_q  <= '0;
            serve_cnt_q  <= '0;
            serve_side_q <= SIDE_ONE;
            winner_q     <= SIDE_ONE;
            serve_go_q   <= 1'b0;
            conceder_q   <= SIDE_ONE;
        end else begin
            state_q      <= state_d;
            score_one_q  <= score_one_d;
            score_two_q  <= score_two_d;
            serve_cnt_q  <= serve_cnt_d;
            serve_side_q <= serve_side_d;
            winner_q     <= winner_d;
            serve_go_q   <= serve_go_d;
            conceder_q   <= conceder_d;
        end
    end

    assign game_active = (state_q == ST_PLAY);
    assign match_over  = (state_q == ST_WIN);
    assign serve_side  = serve_side_q;
    assign serve_go    = serve_go_q;
    assign score_one   = score_one_q;
    assign score_two   = score_two_q;
    assign winner      = winner_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller (WIN_SCORE=3, SERVE_CYCLES=4,
// SCORE_W=4). A behavioural model of the match rules predicts every output;
// directed scenarios come first, then randomized matches.
`timescale 1ns/1ps
module tb_match_controller;
    import match_pkg::*;

    localparam int         WS   = 3;
    localparam int         SW   = 4;
    localparam int         SC   = 4;
    localparam int         SMAX = 15;
    localparam logic [7:0] SEED = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          goal_valid = 1'b0;
    logic          goal_side = 1'b0;
    logic          pause_req = 1'b0;
    logic          game_active;
    logic          serve_side;
    logic          serve_go;
    logic [SW-1:0] score_one;
    logic [SW-1:0] score_two;
    logic          match_over;
    logic          winner;
    logic [2:0]    state_o;

    match_controller #(
        .WIN_SCORE    (WS),
        .SCORE_W      (SW),
        .SERVE_CYCLES (SC),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .goal_valid  (goal_valid),
        .goal_side   (goal_side),
        .pause_req   (pause_req),
        .game_active (game_active),
        .serve_side  (serve_side),
        .serve_go    (serve_go),
        .score_one   (score_one),
        .score_two   (score_two),
        .match_over  (match_over),
        .winner      (winner),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the match.
    state_e     m_state;
    int         m_score [2];
    logic       m_side;
    logic       m_winner;
    logic [7:0] m_lfsr;

    // Random source: x^8+x^6+x^5+x^4 polynomial as a parity over the tap mask.
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    function automatic bit wins(input int s, input int o);
`ifdef MATCH_CTRL_DEUCE_EN
        return (s >= WS) && (s - o >= 2);
`else
        return s == WS;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit go);
        chk({tag, ":state"},       int'(state_o),     int'(m_state));
        chk({tag, ":score_one"},   int'(score_one),   m_score[0]);
        chk({tag, ":score_two"},   int'(score_two),   m_score[1]);
        chk({tag, ":serve_side"},  int'(serve_side),  int'(m_side));
        chk({tag, ":game_active"}, int'(game_active), int'(m_state == ST_PLAY));
        chk({tag, ":match_over"},  int'(match_over),  int'(m_state == ST_WIN));
        chk({tag, ":winner"},      int'(winner),      int'(m_winner));
        chk({tag, ":serve_go"},    int'(serve_go),    int'(go));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start = 1'b0; goal_valid = 1'b0; goal_side = 1'b0; pause_req = 1'b0;
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_score[0] = 0; m_score[1] = 0;
        m_side = 1'b0; m_winner = 1'b0;
    endtask

    task automatic rst_pulse(input string tag);
        rst = 1'b1; clear_inputs();
        tick();
        rst = 1'b0;
        model_reset();
        check_all(tag, 1'b0);
    endtask

    // Remaining SERVE cycles after the first, then the hand-over to PLAY.
    // Irrelevant inputs are driven randomly; all must be ignored.
    task automatic serve_phase(input string tag);
        for (int i = 1; i <= SC; i++) begin
            goal_valid = 1'($urandom); goal_side = 1'($urandom);
            pause_req = 1'($urandom); start = 1'($urandom);
            tick();
            clear_inputs();
            if (i == SC) begin
                m_state = ST_PLAY;
                check_all({tag, ":play"}, 1'b1);
            end else begin
                check_all({tag, ":serve"}, 1'b0);
            end
        end
    endtask

    task automatic do_start(input string tag, input bit run_serve);
        logic exp_side;
        exp_side = m_lfsr[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        m_state = ST_SERVE; m_score[0] = 0; m_score[1] = 0; m_side = exp_side;
        check_all({tag, ":enter"}, 1'b0);
        if (run_serve) serve_phase(tag);
    endtask

    task automatic play_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_all({tag, ":play"}, 1'b0);
        end
    endtask

    // side = line crossed: 1 gives the point to player one.
    task automatic goal(input string tag, input bit side, input bit with_pause, input bit run_serve);
        int sc;
        goal_valid = 1'b1; goal_side = side; pause_req = with_pause;
        tick();
        clear_inputs();
        m_state = ST_POINT;
        check_all({tag, ":point"}, 1'b0);
        tick();
        sc = side ? 0 : 1;
        m_score[sc] = (m_score[sc] < SMAX) ? m_score[sc] + 1 : SMAX;
        m_side = side;
        if (wins(m_score[sc], m_score[1 - sc])) begin
            m_state = ST_WIN; m_winner = 1'(sc);
        end else begin
            m_state = ST_SERVE;
        end
        check_all({tag, ":scored"}, 1'b0);
        if (m_state == ST_SERVE && run_serve) serve_phase(tag);
    endtask

    task automatic pause_seq(input string tag, input int n);
        pause_req = 1'b1;
        tick();
        clear_inputs();
        m_state = ST_PAUSE;
        check_all({tag, ":paused"}, 1'b0);
        for (int i = 0; i < n; i++) begin
            goal_valid = 1'b1; goal_side = 1'($urandom); start = 1'($urandom);
            tick();
            clear_inputs();
            check_all({tag, ":hold"}, 1'b0);
        end
        pause_req = 1'b1;
        tick();
        clear_inputs();
        m_state = ST_PLAY;
        check_all({tag, ":resume"}, 1'b0);
    endtask

    // Cycles in IDLE or WIN with everything except start toggling.
    task automatic idle_noise(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            goal_valid = 1'($urandom); goal_side = 1'($urandom); pause_req = 1'($urandom);
            tick();
            clear_inputs();
            check_all(tag, 1'b0);
        end
    endtask

    initial begin
        model_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_all("reset", 1'b0);

        idle_noise("idle_ignore", 3);

        // First match: three goals for player one.
        do_start("start1", 1'b1);
        play_idle("after_go", 2);
        goal("g1", 1'b1, 1'b0, 1'b1);
        goal("g2", 1'b1, 1'b0, 1'b1);
        goal("g3", 1'b1, 1'b0, 1'b1);
        chk("win3:match_over", int'(match_over), 1);
        chk("win3:winner", int'(winner), 0);
        idle_noise("win_hold", 3);

        // Restart from WIN, pause with goals inside, goal+pause together.
        do_start("restart", 1'b1);
        pause_seq("pause1", 3);
        play_idle("post_pause", 1);
        goal("goal_pause", 1'b0, 1'b1, 1'b1);

        // Reach 2-2, then player one scores: deuce build continues.
        goal("d1", 1'b1, 1'b0, 1'b1);
        goal("d2", 1'b0, 1'b0, 1'b1);
        goal("d3", 1'b1, 1'b0, 1'b1);
        goal("d4", 1'b1, 1'b0, 1'b1);
        if (m_state != ST_WIN) goal("d5", 1'b1, 1'b0, 1'b1);
        chk("deuce:winner", int'(winner), 0);

        // Reset in the second SERVE cycle after a point.
        do_start("rst_serve", 1'b1);
        goal("pre_rst", 1'b0, 1'b0, 1'b0);
        tick();
        check_all("serve_cyc2", 1'b0);
        rst_pulse("rst_mid_serve");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("seed_reload:serve_side", int'(serve_side), int'(SEED[0]));
        m_state = ST_SERVE; m_side = SEED[0];
        serve_phase("after_rst");

        // Reset in PAUSE.
        pause_req = 1'b1;
        tick();
        clear_inputs();
        m_state = ST_PAUSE;
        check_all("pre_rst_pause", 1'b0);
        rst_pulse("rst_mid_pause");

        // Randomized matches.
        for (int m = 0; m < 12; m++) begin
            int guard;
            idle_noise("rnd_idle", int'($urandom_range(0, 5)));
            do_start("rnd_start", 1'b1);
            guard = 0;
            while (m_state != ST_WIN && guard < 60) begin
                int r;
                r = int'($urandom_range(0, 9));
                guard++;
                if (r < 2) begin
                    pause_seq("rnd_pause", int'($urandom_range(0, 3)));
                end else begin
                    play_idle("rnd_play", int'($urandom_range(0, 2)));
                    goal("rnd_goal", 1'($urandom), r == 9, 1'b1);
                end
            end
            if (m_state != ST_WIN) rst_pulse("rnd_abort");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 The block SHALL take parameter WIN_SCORE, default 7, meaning points needed to win a match.
REQ-002 The block SHALL take parameter SCORE_W, default 4, meaning score register width; WIN_SCORE+1 SHALL fit in SCORE_W bits (elaboration check).
REQ-003 The block SHALL take parameter SERVE_CYCLES, default 150000000, meaning serve-hold duration in clk cycles (minimum 1).
REQ-004 The block SHALL take parameter LFSR_SEED, default 8'hA5, meaning non-zero seed for serve randomiser.
REQ-005 Port clk, input, 1, the single system clock.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port start, input, 1, single-cycle pulse that begins a match from IDLE.
REQ-008 Port goal_valid, input, 1, single-cycle goal event from the ball engine.
REQ-009 Port goal_side, input, 1, qualifies goal_valid: 0 = ball crossed player one's line (point to two), 1 = player two's line (point to one).
REQ-010 Port pause_req, input, 1, single-cycle pause toggle request.
REQ-011 Port game_active, output, 1, high only in PLAY; gates paddle and ball motion.
REQ-012 Port serve_side, output, 1, 0 = player one serves, 1 = player two serves; valid in SERVE states.
REQ-013 Port serve_go, output, 1, one-cycle pulse on the SERVE->PLAY transition.
REQ-014 Port score_one / score_two, output, SCORE_W each, current points.
REQ-015 Port match_over, output, 1, high in WIN state; winner, output, 1, 0 = one, 1 = two, valid when match_over.
REQ-016 Port state_o, output, 3, current state encoding for display logic.

Function
REQ-017 States SHALL be IDLE, SERVE, PLAY, PAUSE, POINT, WIN.
REQ-018 IDLE -> SERVE on start; serve_side SHALL take LFSR bit 0 in that cycle.
REQ-019 SERVE SHALL hold exactly SERVE_CYCLES cycles (counter 0..SERVE_CYCLES-1), then -> PLAY with serve_go pulsed for one cycle.
REQ-020 PLAY -> POINT on goal_valid; goal_valid outside PLAY SHALL be ignored.
REQ-021 POINT (one cycle): increment scorer's score; serve_side SHALL become the conceding player; -> WIN if win rule met on the new score, else -> SERVE.
REQ-022 Win rule (base): scorer's new score == WIN_SCORE.
REQ-023 PLAY -> PAUSE on pause_req; PAUSE -> PLAY on pause_req; pause_req elsewhere ignored; goal_valid and pause_req same cycle in PLAY: goal takes priority.
REQ-024 WIN SHALL be held until start, which clears both scores and -> SERVE with random serve_side.
REQ-025 start outside IDLE/WIN SHALL be ignored.
REQ-026 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL advance every cycle, never reaching all-zero.
REQ-027 Scores SHALL saturate at 2^SCORE_W-1, never wrap.

Reset
REQ-028 On rst: state IDLE, scores 0, serve counter 0, serve_side 0, winner 0, serve_go 0, game_active 0, match_over 0, LFSR = LFSR_SEED; rst mid-SERVE or mid-PAUSE SHALL abort to IDLE next cycle.

Configuration
REQ-029 Macro MATCH_CTRL_DEUCE_EN defined: win rule SHALL be scorer's new score >= WIN_SCORE and lead >= 2; undefined: REQ-022 rule only, no lead comparison logic.

Structure
REQ-030 Package match_pkg SHALL hold the state enum (3-bit), side encoding constants SIDE_ONE=0/SIDE_TWO=1.
REQ-031 Sub-module serve_lfsr SHALL implement the LFSR (ports clk, rst, seed, q[7:0]).

Verification (WIN_SCORE=3, SERVE_CYCLES=4, SCORE_W=4)
REQ-032 rst, start -> SERVE 4 cycles, serve_go single pulse, game_active high from cycle 5.
REQ-033 Three goal_side=1 goals in PLAY -> score_one 1,2,3, serve_side=1 after each, match_over=1, winner=0, score_two=0.
REQ-034 goal_valid during SERVE and PAUSE -> scores unchanged, state unchanged.
REQ-035 pause_req in PLAY, then goal_valid, then pause_req -> no score change, PLAY resumes; simultaneous goal+pause in PLAY -> POINT.
REQ-036 DEUCE_EN: scores 2-2, one scores -> 3-2 continues; one scores -> 4-2 WIN winner=0; without macro 3-2 is WIN.
REQ-037 rst asserted at SERVE cycle 2 -> IDLE, scores 0, LFSR = seed next cycle.
